detector_mensajes_multicanal: RTL

//  Parametrised successor of the single-letter stepper message detector. Sits between the UART

---
 rtl/detector_mensajes_pkg.sv | 36 +++
 rtl/detector_mensajes_multicanal_if.sv | 9 +
 rtl/acumulador_decimal.sv | 50 +++++
 rtl/detector_mensajes_multicanal.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/detector_mensajes_pkg.sv
// Shared constants, FSM encoding and constant-width helpers for the multichannel message detector.
package detector_mensajes_pkg;

  localparam logic [7:0] ASCII_0       = 8'd48;
  localparam logic [7:0] ASCII_9       = 8'd57;
  localparam logic [7:0] TERM_ADELANTE = 8'd35;
  localparam logic [7:0] TERM_ATRAS    = 8'd33;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    WAIT = 2'd2,
    DATA = 2'd3
  } estado_e;

  // Smallest r with 2**r >= v.
  function automatic int unsigned clog2(input longint unsigned v);
    int unsigned     r;
    longint unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/detector_mensajes_multicanal_if.sv
// UART byte handshake: the receiver offers a byte with rdy, the detector consumes it with rdy_clr.
interface detector_mensajes_multicanal_if;
  logic       rdy;
  logic [7:0] dout;
  logic       rdy_clr;

  modport master (output rdy, output dout, input rdy_clr);
  modport slave  (input rdy, input dout, output rdy_clr);
endinterface

// File: rtl/acumulador_decimal.sv
// Decimal digit accumulator: acc = acc*10 + digit, with a digit counter and a full flag.
module acumulador_decimal
  import detector_mensajes_pkg::*;
#(
  parameter  int unsigned ANCHO_ACC   = 10,
  parameter  int unsigned MAX_DIGITOS = 3,
  localparam int unsigned ANCHO_CNT   = clog2(MAX_DIGITOS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 cargar,
  input  logic [3:0]           digito,
  output logic [ANCHO_ACC-1:0] acc,
  output logic [ANCHO_CNT-1:0] cnt,
  output logic                 lleno_c
);

  logic [ANCHO_ACC-1:0] acc_q, acc_d;
  logic [ANCHO_CNT-1:0] cnt_q, cnt_d;

  assign lleno_c = (cnt_q == ANCHO_CNT'(MAX_DIGITOS));

  // The width is sized for MAX_DIGITOS nines, so the product never wraps.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (cargar && !lleno_c) begin
      acc_d = acc_q * ANCHO_ACC'(10) + ANCHO_ACC'(digito);
      cnt_d = cnt_q + ANCHO_CNT'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc = acc_q;
  assign cnt = cnt_q;

endmodule

// File: rtl/detector_mensajes_multicanal.sv
// Decodes <letter><digits><'#'|'!'> frames from a UART into per-channel motor value/direction outputs,
// with saturation, digit limit, inter-byte timeout, resync on a new letter and an abort pulse.
module detector_mensajes_multicanal
  import detector_mensajes_pkg::*;
#(
  parameter int unsigned N_CANALES      = 4,
  parameter int unsigned ANCHO          = 8,
  parameter int unsigned MAX_VALOR      = 255,
  parameter int unsigned MAX_DIGITOS    = 3,
  parameter int unsigned TIMEOUT_CICLOS = 5_000_000
) (
  input  logic                         CLOCK_50,
  input  logic                         RESET_N,
  detector_mensajes_multicanal_if.slave bus,
  input  logic [8*N_CANALES-1:0]       LETRAS_DETECTAR,
  output logic [ANCHO*N_CANALES-1:0]   SALIDA_AL_MOTOR,
  output logic [N_CANALES-1:0]         SALIDA_DIRECCION,
  output logic [N_CANALES-1:0]         SALIDA_VALIDA,
  output logic [N_CANALES-1:0]         SALIDA_SATURADA,
  output logic                         ERROR_TRAMA
);

  localparam int unsigned ANCHO_ACC = clog2(pow10(MAX_DIGITOS));
  localparam int unsigned ANCHO_CNT = clog2(MAX_DIGITOS + 1);
  localparam int unsigned ANCHO_CH  = (N_CANALES > 1) ? clog2(N_CANALES) : 1;
  localparam int unsigned ANCHO_TMR = (TIMEOUT_CICLOS > 1) ? clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [ANCHO_TMR-1:0] TMR_FIN =
    ANCHO_TMR'((TIMEOUT_CICLOS == 0) ? 0 : TIMEOUT_CICLOS - 1);

  estado_e                      estado_q, estado_d;
  logic [ANCHO_CH-1:0]          ch_q, ch_d;
  logic [ANCHO_TMR-1:0]         timer_q, timer_d;
  logic                         guard_q, guard_d;
  logic                         rdy_clr_q, rdy_clr_d;
  logic [ANCHO*N_CANALES-1:0]   motor_q, motor_d;
  logic [N_CANALES-1:0]         dir_q, dir_d;
  logic [N_CANALES-1:0]         valida_q, valida_d;
  logic [N_CANALES-1:0]         sat_q, sat_d;
  logic                         error_q, error_d;

  logic                         acc_clr_c, acc_cargar_c, lleno_c;
  logic [ANCHO_ACC-1:0]         acc;
  logic [ANCHO_CNT-1:0]         cnt;
  logic                         es_digito_c, es_term_c, hay_letra_c, sat_c;
  logic [ANCHO_CH-1:0]          letra_idx_c;
  logic [ANCHO-1:0]             valor_c;

  acumulador_decimal #(
    .ANCHO_ACC   (ANCHO_ACC),
    .MAX_DIGITOS (MAX_DIGITOS)
  ) u_acc (
    .clk     (CLOCK_50),
    .rst_n   (RESET_N),
    .clr     (acc_clr_c),
    .cargar  (acc_cargar_c),
    .digito  (4'(bus.dout - ASCII_0)),
    .acc     (acc),
    .cnt     (cnt),
    .lleno_c (lleno_c)
  );

  assign es_digito_c = (bus.dout >= ASCII_0) && (bus.dout <= ASCII_9);
  assign es_term_c   = (bus.dout == TERM_ADELANTE) || (bus.dout == TERM_ATRAS);
  assign sat_c       = (32'(acc) > MAX_VALOR);
  assign valor_c     = sat_c ? ANCHO'(MAX_VALOR) : ANCHO'(acc);

  // Lowest matching channel wins; digits and terminators never count as letters.
  always_comb begin
    hay_letra_c = 1'b0;
    letra_idx_c = '0;
    for (int unsigned i = 0; i < N_CANALES; i++) begin
      if (!hay_letra_c && (bus.dout == LETRAS_DETECTAR[8*i +: 8])) begin
        hay_letra_c = 1'b1;
        letra_idx_c = ANCHO_CH'(i);
      end
    end
    if (es_digito_c || es_term_c) hay_letra_c = 1'b0;
  end

  always_comb begin
    estado_d     = estado_q;
    ch_d         = ch_q;
    timer_d      = timer_q;
    motor_d      = motor_q;
    dir_d        = dir_q;
    sat_d        = sat_q;
    valida_d     = '0;
    error_d      = 1'b0;
    acc_clr_c    = 1'b0;
    acc_cargar_c = 1'b0;
    case (estado_q)
      IDLE: if (bus.rdy && !guard_q) estado_d = HDR;
      HDR: begin
        estado_d = IDLE;
        if (hay_letra_c) begin
          ch_d      = letra_idx_c;
          acc_clr_c = 1'b1;
          timer_d   = '0;
          estado_d  = WAIT;
        end
      end
      WAIT: begin
        if (bus.rdy && !guard_q) begin
          estado_d = DATA;
        end else if (TIMEOUT_CICLOS != 0) begin
          if (timer_q == TMR_FIN) begin
            error_d  = 1'b1;
            estado_d = IDLE;
          end else begin
            timer_d = timer_q + ANCHO_TMR'(1);
          end
        end
      end
      DATA: begin
        timer_d  = '0;
        estado_d = IDLE;
        if (es_digito_c) begin
          if (lleno_c) error_d = 1'b1;
          else begin
            acc_cargar_c = 1'b1;
            estado_d     = WAIT;
          end
        end else if (es_term_c) begin
          if (cnt == '0) error_d = 1'b1;
          else begin
            motor_d[ANCHO*ch_q +: ANCHO] = valor_c;
            dir_d[ch_q]    = (bus.dout == TERM_ADELANTE);
            sat_d[ch_q]    = sat_c;
            valida_d[ch_q] = 1'b1;
          end
        end else if (hay_letra_c) begin
          ch_d      = letra_idx_c;
          acc_clr_c = 1'b1;
          estado_d  = WAIT;
        end else begin
          error_d = 1'b1;
        end
      end
      default: estado_d = IDLE;
    endcase
    // The UART needs a cycle to drop rdy after each consume strobe.
    guard_d   = rdy_clr_q;
    rdy_clr_d = (estado_d == HDR) || (estado_d == DATA);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      estado_q  <= IDLE;
      ch_q      <= '0;
      timer_q   <= '0;
      guard_q   <= 1'b0;
      rdy_clr_q <= 1'b0;
      motor_q   <= '0;
      dir_q     <= '0;
      valida_q  <= '0;
      sat_q     <= '0;
      error_q   <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      ch_q      <= ch_d;
      timer_q   <= timer_d;
      guard_q   <= guard_d;
      rdy_clr_q <= rdy_clr_d;
      motor_q   <= motor_d;
      dir_q     <= dir_d;
      valida_q  <= valida_d;
      sat_q     <= sat_d;
      error_q   <= error_d;
    end
  end

  assign bus.rdy_clr       = rdy_clr_q;
  assign SALIDA_AL_MOTOR   = motor_q;
  assign SALIDA_DIRECCION  = dir_q;
  assign SALIDA_VALIDA     = valida_q;
  assign SALIDA_SATURADA   = sat_q;
  assign ERROR_TRAMA       = error_q;

endmodule
